// File: rtl/morph_frame_ctrl.sv
// Frame-level controller for the binary erosion/dilation stage: applies host config at vsync
// boundaries, tracks line/pixel geometry and raises completion, error and stall pulses.
module morph_frame_ctrl #(
    parameter int unsigned H_DISP      = 1280,
    parameter int unsigned V_DISP      = 720,
    parameter int unsigned TIMEOUT_CYC = 1500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        win_vsync,
    input  logic        win_valid,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_enable,
    input  logic [1:0]  cfg_mode,
    output logic        op_en,
    output logic [1:0]  op_sel,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        line_err,
    output logic        frame_err,
    output logic        stall,
    output logic        busy
);

    localparam logic [11:0] HDisp    = 12'(H_DISP);
    localparam logic [11:0] LastLine = 12'(V_DISP - 1);
    localparam logic [20:0] WdLast   = 21'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StActive, StWaitVs} state_e;

    state_e      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        valid_q, valid_d;
    logic        pending_q, pending_d;
    logic        shadow_en_q, shadow_en_d;
    logic [1:0]  shadow_mode_q, shadow_mode_d;
    logic        act_en_q, act_en_d;
    logic [1:0]  act_mode_q, act_mode_d;
    logic [11:0] pix_cnt_q, pix_cnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [20:0] wd_cnt_q, wd_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        op_en_q, op_en_d;
    logic [1:0]  op_sel_q, op_sel_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        stall_q, stall_d;

    logic        vs_rise, v_fall, cfg_accept, nxt_en;
    logic [1:0]  nxt_mode, start_sel;

    always_comb begin
        vs_rise    = win_vsync & ~vsync_q;
        v_fall     = valid_q & ~win_valid;
        cfg_accept = cfg_valid & ~pending_q;
        nxt_en     = pending_q ? shadow_en_q : act_en_q;
        nxt_mode   = pending_q ? shadow_mode_q : act_mode_q;
        // Alternate mode picks erode on even completed-frame counts, dilate on odd.
        start_sel  = (nxt_mode == 2'd3) ? (frame_cnt_q[0] ? 2'd2 : 2'd1) : nxt_mode;

        state_d       = state_q;
        vsync_d       = win_vsync;
        valid_d       = win_valid;
        pending_d     = pending_q;
        shadow_en_d   = shadow_en_q;
        shadow_mode_d = shadow_mode_q;
        act_en_d      = act_en_q;
        act_mode_d    = act_mode_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        wd_cnt_d      = (state_q == StIdle || vs_rise) ? 21'd0 : wd_cnt_q + 21'd1;
        frame_cnt_d   = frame_cnt_q;
        op_en_d       = op_en_q;
        op_sel_d      = op_sel_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        line_err_d    = 1'b0;
        frame_err_d   = 1'b0;
        stall_d       = 1'b0;

        if (vs_rise) begin
            act_en_d   = nxt_en;
            act_mode_d = nxt_mode;
            pending_d  = 1'b0;
        end
        // A write landing on the boundary cycle becomes the next pending config.
        if (cfg_accept) begin
            shadow_en_d   = cfg_enable;
            shadow_mode_d = cfg_mode;
            pending_d     = 1'b1;
        end

        if (vs_rise) begin
            pix_cnt_d   = 12'd0;
            line_cnt_d  = 12'd0;
            frame_err_d = (state_q == StActive);
            if (nxt_en) begin
                state_d       = StActive;
                frame_start_d = 1'b1;
                op_en_d       = (nxt_mode != 2'd0);
                op_sel_d      = start_sel;
            end else begin
                state_d = StIdle;
                op_en_d = 1'b0;
            end
        end else if (state_q != StIdle && wd_cnt_q == WdLast) begin
            state_d    = StIdle;
            stall_d    = 1'b1;
            op_en_d    = 1'b0;
            pix_cnt_d  = 12'd0;
            line_cnt_d = 12'd0;
        end else if (state_q == StActive) begin
            if (win_valid) begin
                pix_cnt_d = pix_cnt_q + 12'd1;
            end
            if (v_fall) begin
                line_err_d = (pix_cnt_q != HDisp);
                pix_cnt_d  = 12'd0;
                if (line_cnt_q == LastLine) begin
                    line_cnt_d   = 12'd0;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    state_d      = StWaitVs;
                end else begin
                    line_cnt_d = line_cnt_q + 12'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            vsync_q       <= 1'b0;
            valid_q       <= 1'b0;
            pending_q     <= 1'b0;
            shadow_en_q   <= 1'b0;
            shadow_mode_q <= 2'd0;
            act_en_q      <= 1'b0;
            act_mode_q    <= 2'd0;
            pix_cnt_q     <= 12'd0;
            line_cnt_q    <= 12'd0;
            wd_cnt_q      <= 21'd0;
            frame_cnt_q   <= 16'd0;
            op_en_q       <= 1'b0;
            op_sel_q      <= 2'd0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            valid_q       <= valid_d;
            pending_q     <= pending_d;
            shadow_en_q   <= shadow_en_d;
            shadow_mode_q <= shadow_mode_d;
            act_en_q      <= act_en_d;
            act_mode_q    <= act_mode_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            op_en_q       <= op_en_d;
            op_sel_q      <= op_sel_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            line_err_q    <= line_err_d;
            frame_err_q   <= frame_err_d;
            stall_q       <= stall_d;
        end
    end

    assign cfg_ready   = ~pending_q;
    assign op_en       = op_en_q;
    assign op_sel      = op_sel_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign stall       = stall_q;
    assign busy        = (state_q != StIdle);

endmodule
